execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline core; consumes the ID/EX bundle produced by the decode stage.
- Selects forwarded operands, runs the ALU and resolves branches.
- Returns the branch decision and target to the fetch stage combinationally.
- Registers the EX/MEM bundle for the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REGADDR, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- RegWriteE  input  1  register write enable from ID/EX
- ALUSrcE  input  1  1 = operand B is Imm_Ext_E
- MemWriteE  input  1  store enable
- ResultSrcE  input  1  1 = writeback from memory
- BranchE  input  1  beq instruction
- ALUControlE  input  3  ALU operation
- RD1_E  input  XLEN  rs1 register value
- RD2_E  input  XLEN  rs2 register value
- Imm_Ext_E  input  XLEN  extended immediate
- RD_E  input  REGADDR  destination register
- PCE  input  XLEN  PC of instruction
- PCPlus4E  input  XLEN  PC+4
- ForwardAE  input  2  operand A source select, from hazard unit
- ForwardBE  input  2  operand B source select, from hazard unit
- ResultW  input  XLEN  writeback-stage result
- FlushE  input  1  squash this cycle's instruction into the EX/MEM register (bubble)
- PCSrcE  output  1  branch taken (combinational)
- PCTargetE  output  XLEN  PCE + Imm_Ext_E (combinational)
- RegWriteM  output  1  registered
- MemWriteM  output  1  registered
- ResultSrcM  output  1  registered
- RD_M  output  REGADDR  registered
- ALUResultM  output  XLEN  registered ALU result; also the forward source
- WriteDataM  output  XLEN  registered forwarded rs2 value
- PCPlus4M  output  XLEN  registered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On a clk edge with rst=1, every registered output is 0.
- Forward mux A (SrcAE), selected by ForwardAE:
  - 00 -> RD1_E
  - 01 -> ResultW
  - 10 -> ALUResultM (current registered output)
  - 11 -> RD1_E (reserved)
- Forward mux B (WriteDataE): same encoding on RD2_E.
- SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU encodings, all XLEN-bit with wrap-around and carry discarded:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt: signed compare, result 1 or 0
  - 100, 110, 111 -> result 0
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE & ~FlushE. Combinational; no added latency.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
- EX/MEM register, latency 1 cycle. On each clk edge with rst=0:
  - if FlushE=1: RegWriteM=0, MemWriteM=0. All other M outputs load 0.
  - else: all M outputs load their E-stage values, with ALUResultM = ALU result and WriteDataM = WriteDataE.
- Priority: rst over FlushE over normal load.
- Forward from ALUResultM uses the value held before the edge, so back-to-back dependent instructions forward correctly.
- Reset mid-stream: the in-flight instruction is discarded; PCSrcE depends only on inputs, so it may assert during reset. Fetch qualifies PCSrcE with rst.
- No stall input: the stage advances every cycle.

Decomposition:
- Shared package/include holds:
  - ALU op constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101
  - forward select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- One sub-module, alu: inputs A, B, ALUControl; outputs Result and Zero. Purely combinational.
- Forward muxes, branch logic and the EX/MEM register live in execute_cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> every M output is 0 after each edge; deassert -> the next edge loads inputs.
- ALU ops:
  - add RD1_E=5, Imm_Ext_E=7, ALUSrcE=1 -> ALUResultM=12 after 1 cycle.
  - sub 3-5 -> 32'hFFFFFFFE.
  - slt with A=32'h80000000, B=1 -> 1.
  - add 32'hFFFFFFFF + 1 -> 0.
- Forwarding:
  - cycle 1: add x1 = 10 + 20, giving ALUResultM=30.
  - cycle 2: ForwardAE=10, RD1_E=99, Imm=1 -> ALUResultM=31.
  - ForwardBE=01, ResultW=0x55, MemWriteE=1 -> WriteDataM=0x55.
- Branch:
  - BranchE=1, ALUControlE=sub, RD1_E=RD2_E=4, PCE=0x100, Imm=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle.
  - With RD2_E=5 -> PCSrcE=0.
- Flush: FlushE=1 with RegWriteE=1, MemWriteE=1, BranchE=1, taken compare -> PCSrcE=0; after the edge RegWriteM=0, MemWriteM=0 and all data outputs are 0.
- Flush vs reset: rst=1 and FlushE=0 simultaneously -> all outputs 0; FlushE deasserted -> normal load on the next edge.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// Shared constants for the execute stage: ALU operation codes and forward selects.
package execute_cycle_pkg;

  // ALU operation encodings (ALUControlE)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operand forward selects from the hazard unit; 2'b11 is reserved and
  // falls back to the register-file value.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage. Unlisted opcodes yield zero.
module execute_cycle_alu
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic slt_bit;
  assign slt_bit = $signed(A) < $signed(B);

  // Operation select; add/sub wrap and discard the carry
  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt_bit};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteE,
  input  logic               ALUSrcE,
  input  logic               MemWriteE,
  input  logic               ResultSrcE,
  input  logic               BranchE,
  input  logic [2:0]         ALUControlE,
  input  logic [XLEN-1:0]    RD1_E,
  input  logic [XLEN-1:0]    RD2_E,
  input  logic [XLEN-1:0]    Imm_Ext_E,
  input  logic [REGADDR-1:0] RD_E,
  input  logic [XLEN-1:0]    PCE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [XLEN-1:0]    ResultW,
  input  logic               FlushE,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               ResultSrcM,
  output logic [REGADDR-1:0] RD_M,
  output logic [XLEN-1:0]    ALUResultM,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [XLEN-1:0]    PCPlus4M
);

  logic [XLEN-1:0]    src_a, write_data_e, src_b, alu_result;
  logic               zero_e;

  logic               reg_write_q, mem_write_q, result_src_q;
  logic [REGADDR-1:0] rd_q;
  logic [XLEN-1:0]    alu_result_q, write_data_q, pc_plus4_q;

  // Forward muxes; the MEM source is the EX/MEM value held before this edge
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
    write_data_e = RD2_E;
    case (ForwardBE)
      FWD_WB:  write_data_e = ResultW;
      FWD_MEM: write_data_e = alu_result_q;
      default: write_data_e = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

  execute_cycle_alu #(.XLEN(XLEN)) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (zero_e)
  );

  // A flushed instruction must never redirect fetch
  assign PCSrcE    = BranchE & zero_e & ~FlushE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM register: reset beats flush, flush inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      result_src_q <= ResultSrcE;
      rd_q         <= RD_E;
      alu_result_q <= alu_result;
      write_data_q <= write_data_e;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle with hand-computed expected values.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, FlushE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_cycle #(.XLEN(32), .REGADDR(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    FlushE = 0; ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, ".RegWriteM"},  {31'b0, RegWriteM},  32'h0);
    chk({tag, ".MemWriteM"},  {31'b0, MemWriteM},  32'h0);
    chk({tag, ".ResultSrcM"}, {31'b0, ResultSrcM}, 32'h0);
    chk({tag, ".RD_M"},       {27'b0, RD_M},       32'h0);
    chk({tag, ".ALUResultM"}, ALUResultM,          32'h0);
    chk({tag, ".WriteDataM"}, WriteDataM,          32'h0);
    chk({tag, ".PCPlus4M"},   PCPlus4M,            32'h0);
  endtask

  // Stage one ALU op with register operands (or immediate if imm_sel)
  task automatic alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic imm_sel);
    idle();
    ALUControlE = op; RD1_E = a; ALUSrcE = imm_sel;
    if (imm_sel) Imm_Ext_E = b; else RD2_E = b;
  endtask

  initial begin
    idle();
    rst = 1;
    // Nonzero inputs while reset is held: add 5 + imm 7
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; ALUSrcE = 1;
    RD1_E = 5; Imm_Ext_E = 7; RD2_E = 9; RD_E = 5'd3; PCPlus4E = 32'h8;
    tick(); chk_m_zero("rst1");
    tick(); chk_m_zero("rst2");
    rst = 0;
    tick();
    chk("add.ALUResultM", ALUResultM, 32'd12);
    chk("add.RegWriteM",  {31'b0, RegWriteM},  32'h1);
    chk("add.MemWriteM",  {31'b0, MemWriteM},  32'h1);
    chk("add.ResultSrcM", {31'b0, ResultSrcM}, 32'h1);
    chk("add.RD_M",       {27'b0, RD_M},       32'd3);
    chk("add.WriteDataM", WriteDataM, 32'd9);
    chk("add.PCPlus4M",   PCPlus4M,   32'h8);

    // ALU op table
    alu_op(3'b001, 32'd3, 32'd5, 0);               tick(); chk("sub", ALUResultM, 32'hFFFFFFFE);
    alu_op(3'b101, 32'h80000000, 32'd1, 1);        tick(); chk("slt_neg", ALUResultM, 32'd1);
    alu_op(3'b101, 32'd1, 32'h80000000, 0);        tick(); chk("slt_pos", ALUResultM, 32'd0);
    alu_op(3'b000, 32'hFFFFFFFF, 32'd1, 1);        tick(); chk("add_wrap", ALUResultM, 32'd0);
    alu_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 0); tick(); chk("and", ALUResultM, 32'h00F0_1200);
    alu_op(3'b011, 32'hF000_0001, 32'h0000_0F10, 0); tick(); chk("or", ALUResultM, 32'hF000_0F11);
    alu_op(3'b110, 32'd7, 32'd9, 0);               tick(); chk("op110", ALUResultM, 32'd0);

    // Forwarding: x1 = 10 + 20, then consumer takes ALUResultM via FWD_MEM
    alu_op(3'b000, 32'd10, 32'd20, 0); tick(); chk("fwd.prod", ALUResultM, 32'd30);
    alu_op(3'b000, 32'd99, 32'd1, 1); ForwardAE = 2'b10;
    tick(); chk("fwd.mem_a", ALUResultM, 32'd31);
    idle(); ForwardBE = 2'b01; ResultW = 32'h55; RD2_E = 32'h77; MemWriteE = 1;
    ALUSrcE = 1; Imm_Ext_E = 32'd4; RD1_E = 32'd2;
    tick();
    chk("fwd.wb_b", WriteDataM, 32'h55);
    chk("fwd.wb_b.alu", ALUResultM, 32'd6);
    chk("fwd.wb_b.mw", {31'b0, MemWriteM}, 32'h1);
    idle(); ForwardAE = 2'b01; ResultW = 32'h100; RD1_E = 32'd1; ALUSrcE = 1; Imm_Ext_E = 32'd3;
    tick(); chk("fwd.wb_a", ALUResultM, 32'h103);
    idle(); ForwardAE = 2'b11; ResultW = 32'h100; RD1_E = 32'd7; ALUSrcE = 1; Imm_Ext_E = 32'd1;
    tick(); chk("fwd.rsvd_a", ALUResultM, 32'd8);
    // ALUResultM is 8 here; FWD_MEM on B then feeds WriteDataE
    idle(); ForwardBE = 2'b10; RD2_E = 32'd50; ALUSrcE = 1; Imm_Ext_E = 32'd0;
    tick(); chk("fwd.mem_b", WriteDataM, 32'd8);

    // Branch: beq taken and not taken, checked combinationally before the edge
    idle(); BranchE = 1; ALUControlE = 3'b001; RD1_E = 4; RD2_E = 4;
    PCE = 32'h100; Imm_Ext_E = 32'h20; PCPlus4E = 32'h104; RD_E = 5'd7;
    #1;
    chk("br.taken", {31'b0, PCSrcE}, 32'h1);
    chk("br.target", PCTargetE, 32'h120);
    RD2_E = 5; #1;
    chk("br.not_taken", {31'b0, PCSrcE}, 32'h0);
    PCE = 32'hFFFF_FFF0; #1;
    chk("br.target_wrap", PCTargetE, 32'h10);
    tick(); // loads RD_M=7, PCPlus4M=0x104, WriteDataM=5 so the flush has something to clear

    // Flush: taken compare with writes enabled becomes a bubble
    idle(); FlushE = 1; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; BranchE = 1;
    ALUControlE = 3'b001; RD1_E = 4; RD2_E = 4; PCE = 32'h200; Imm_Ext_E = 32'h8;
    PCPlus4E = 32'h204; RD_E = 5'd9;
    #1; chk("flush.pcsrc", {31'b0, PCSrcE}, 32'h0);
    tick(); chk_m_zero("flush");

    // Reset with flush low, then normal load once released
    idle(); rst = 1; RegWriteE = 1; RD1_E = 32'd40; RD2_E = 32'd2; PCPlus4E = 32'h44; RD_E = 5'd4;
    tick(); chk_m_zero("rst_mid");
    rst = 0;
    tick();
    chk("post_rst.alu", ALUResultM, 32'd42);
    chk("post_rst.rw", {31'b0, RegWriteM}, 32'h1);
    chk("post_rst.pc4", PCPlus4M, 32'h44);
    chk("post_rst.rd", {27'b0, RD_M}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
